dmem_bus_ctrl: RTL

M-stage data-memory bus controller placed between the store/load helper and the external data memory. It takes one load or store per request, steers store data onto the correct byte lanes, runs a request/acknowledge transaction with variable-latency memory, and holds the pipeline stalled until the access completes. It returns the raw memory word, which the load helper then extracts and extends. It also flags misaligned accesses and bus timeouts.

---
 rtl/dmem_bus_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dmem_bus_ctrl.sv
// M-stage data-memory bus controller: lane steering, req/ack handshake with timeout, pipeline stall.
// Optional store trace is enabled by defining DMEM_TRACE_EN.
module dmem_bus_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [3:0]  m_byteen,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [31:0] m_pc,
  output logic        m_stall,
  output logic [31:0] m_rdata,
  output logic        m_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_e;

  localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

  state_e      state_q;
  logic        we_q;
  logic [3:0]  byteen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] pc_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [7:0]  cnt_q;
  logic        busy_s;

  // A store's enables must sit exactly where its address points; loads must be word aligned.
  function automatic logic misaligned(input logic we, input logic [3:0] be, input logic [1:0] a);
    logic bad;
    if (!we) begin
      bad = (a != 2'b00);
    end else begin
      case (be)
        4'b0001: bad = (a != 2'b00);
        4'b0010: bad = (a != 2'b01);
        4'b0100: bad = (a != 2'b10);
        4'b1000: bad = (a != 2'b11);
        4'b0011: bad = (a != 2'b00);
        4'b1100: bad = (a != 2'b10);
        4'b1111: bad = (a != 2'b00);
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  function automatic logic [31:0] steer(input logic [3:0] be, input logic [31:0] d);
    logic [31:0] s;
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: s = {4{d[7:0]}};
      4'b0011, 4'b1100:                   s = {2{d[15:0]}};
      default:                            s = d;
    endcase
    return s;
  endfunction

  // Transaction FSM with all request latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      byteen_q <= 4'b0000;
      addr_q   <= 32'h0000_0000;
      wdata_q  <= 32'h0000_0000;
      pc_q     <= 32'h0000_0000;
      rdata_q  <= 32'h0000_0000;
      err_q    <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (m_req) begin
            we_q     <= m_we;
            byteen_q <= m_we ? m_byteen : 4'b0000;
            addr_q   <= {m_addr[31:2], 2'b00};
            wdata_q  <= m_we ? steer(m_byteen, m_wdata) : 32'h0000_0000;
            pc_q     <= m_pc;
            rdata_q  <= 32'h0000_0000;
            cnt_q    <= 8'd0;
            if (misaligned(m_we, m_byteen, m_addr[1:0])) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              err_q   <= 1'b0;
              state_q <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (bus_ack) begin
            rdata_q <= we_q ? 32'h0000_0000 : bus_rdata;
            state_q <= S_DONE;
`ifdef DMEM_TRACE_EN
            if (we_q) $display("@%h: *%h <= %h", pc_q, addr_q, wdata_q);
`endif
          end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= cnt_q + 8'd1;
            err_q   <= 1'b1;
            rdata_q <= 32'h0000_0000;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        // The completing instruction's m_req is still visible here and must not re-issue.
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifndef DMEM_TRACE_EN
  logic unused_pc_s;
  assign unused_pc_s = ^pc_q;
`endif

  assign busy_s     = (state_q == S_BUSY);
  assign bus_req    = busy_s;
  assign bus_we     = busy_s & we_q;
  assign bus_addr   = busy_s ? addr_q : 32'h0000_0000;
  assign bus_byteen = busy_s ? byteen_q : 4'b0000;
  assign bus_wdata  = busy_s ? wdata_q : 32'h0000_0000;
  assign m_rdata    = rdata_q;
  assign m_err      = (state_q == S_DONE) & err_q;

  // Stall is raised in the request cycle itself and released in DONE.
  always_comb begin
    m_stall = 1'b0;
    case (state_q)
      S_IDLE:  m_stall = m_req & ~reset;
      S_BUSY:  m_stall = 1'b1;
      S_DONE:  m_stall = 1'b0;
      default: m_stall = 1'b0;
    endcase
  end

endmodule
